// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI host sequencer.
package spi_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PUSH  = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  // Master TX FIFO depth; a burst may use at most depth-1 entries
  localparam int SPI_TX_FIFO_DEPTH = 16;
  // Byte clocked out while reading
  localparam logic [7:0] SPI_DUMMY_BYTE = 8'h00;
  localparam int SPI_ADDR_W = 7;

  // Larger of two integers, used to size the shared timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag, shared by the GAP and DRAIN waits.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         Mclk,
  input  logic         nReset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; decrement saturates at zero so the count never wraps
  always_ff @(posedge Mclk) begin
    if (!nReset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/spi_host_sequencer.sv
// Turns host commands into a paced byte stream for the SPI master, holding
// Address/Read_RQ steady for the whole transaction. Pacing is open-loop since
// the master has no back-pressure: GAP between pushes, DRAIN after a burst.
module spi_host_sequencer
  import spi_seq_pkg::*;
#(
  parameter int GAP_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 512,
  parameter int MAX_BURST    = 15   // must stay below SPI_TX_FIFO_DEPTH
) (
  input  logic                  Mclk,
  input  logic                  nReset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd,
  input  logic [SPI_ADDR_W-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic [7:0]            wr_data,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  output logic [7:0]            BUS_IN,
  output logic                  Data_Available,
  output logic [SPI_ADDR_W-1:0] Address,
  output logic                  Read_RQ,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len
);

  localparam int TMR_W = $clog2(max_int(GAP_CYCLES, DRAIN_CYCLES) + 1);
  localparam logic [3:0]       MAX_LEN    = 4'(MAX_BURST);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

  seq_state_t r_state, w_state_next;

  logic                  r_rd;
  logic [3:0]            r_len;
  logic [3:0]            r_count;
  logic [7:0]            r_bus_in;
  logic                  r_data_avail;
  logic [SPI_ADDR_W-1:0] r_address;
  logic                  r_read_rq;
  logic                  r_err_len;
  logic                  r_tmr_first;

  logic             w_len_ok;
  logic             w_accept;
  logic             w_push;
  logic             w_tmr_load;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_cmd_ready;
  logic             w_wr_ready;
  logic             w_busy;
  logic             w_done;

  assign w_len_ok = (cmd_len != 4'd0) && (cmd_len <= MAX_LEN);

  // State register
  always_ff @(posedge Mclk) begin
    if (!nReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle strobes. GAP/DRAIN spend their first
  // cycle loading the timer, so each lasts N+1 cycles.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_push       = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_dec    = 1'b0;
    w_tmr_val    = GAP_LOAD;
    w_cmd_ready  = 1'b0;
    w_wr_ready   = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy      = 1'b0;
        w_cmd_ready = nReset;
        w_accept    = cmd_valid && nReset;
        if (w_accept && w_len_ok) begin
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        w_state_next = PUSH;
      end
      PUSH: begin
        if (r_rd || wr_data_valid) begin
          w_push       = 1'b1;
          w_wr_ready   = !r_rd && nReset;
          w_state_next = (r_count > 4'd1) ? GAP : DRAIN;
        end
      end
      GAP, DRAIN: begin
        w_tmr_val = (r_state == GAP) ? GAP_LOAD : DRAIN_LOAD;
        if (r_tmr_first) begin
          w_tmr_load = 1'b1;
        end else if (w_tmr_zero) begin
          w_state_next = (r_state == GAP) ? PUSH : DONE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Command capture, byte counter and master-facing registered outputs
  always_ff @(posedge Mclk) begin
    if (!nReset) begin
      r_rd         <= 1'b0;
      r_len        <= 4'd0;
      r_count      <= 4'd0;
      r_bus_in     <= 8'h00;
      r_data_avail <= 1'b0;
      r_address    <= '0;
      r_read_rq    <= 1'b0;
      r_err_len    <= 1'b0;
      r_tmr_first  <= 1'b0;
    end else begin
      r_data_avail <= w_push;
      r_tmr_first  <= w_push;
      r_err_len    <= w_accept && !w_len_ok;
      if (w_accept && w_len_ok) begin
        r_rd      <= cmd_rd;
        r_len     <= cmd_len;
        r_address <= cmd_addr;
        r_read_rq <= cmd_rd;
      end
      if (r_state == SETUP) begin
        r_count <= r_len;
      end else if (w_push && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      if (w_push) begin
        r_bus_in <= r_rd ? SPI_DUMMY_BYTE : wr_data;
      end
      if (r_state == DONE) begin
        r_read_rq <= 1'b0;
      end
    end
  end

  seq_timer #(
    .W(TMR_W)
  ) u_timer (
    .Mclk       (Mclk),
    .nReset     (nReset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  assign cmd_ready      = w_cmd_ready;
  assign wr_data_ready  = w_wr_ready;
  assign BUS_IN         = r_bus_in;
  assign Data_Available = r_data_avail;
  assign Address        = r_address;
  assign Read_RQ        = r_read_rq;
  assign busy           = w_busy;
  assign done           = w_done;
  assign err_len        = r_err_len;

endmodule

// File: tb/tb_spi_host_sequencer.sv
// Randomized self-checking bench for spi_host_sequencer. Expected push and
// done times come from the timing rules: first push opportunity 2 cycles after
// accept, Data_Available one cycle after a push, pushes GAP+2 apart, done
// DRAIN+1 cycles after the last Data_Available.
module tb_spi_host_sequencer;

  localparam int GAP   = 4;
  localparam int DRAIN = 512;
  localparam int MAXB  = 15;
  localparam int G8    = 2;
  localparam int D8    = 8;
  localparam int M8    = 8;

  logic       Mclk = 1'b0;
  logic       nReset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       c8_valid = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [3:0] cmd_len = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_data_valid = 1'b0;

  logic       cmd_ready, wr_data_ready, Data_Available, Read_RQ, busy, done, err_len;
  logic [7:0] BUS_IN;
  logic [6:0] Address;
  logic       cmd_ready_8, wr_data_ready_8, Data_Available_8, Read_RQ_8, busy_8, done_8, err_len_8;
  logic [7:0] BUS_IN_8;
  logic [6:0] Address_8;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  spi_host_sequencer #(.GAP_CYCLES(GAP), .DRAIN_CYCLES(DRAIN), .MAX_BURST(MAXB)) dut (
    .Mclk(Mclk), .nReset(nReset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .BUS_IN(BUS_IN),
    .Data_Available(Data_Available), .Address(Address), .Read_RQ(Read_RQ),
    .busy(busy), .done(done), .err_len(err_len)
  );

  spi_host_sequencer #(.GAP_CYCLES(G8), .DRAIN_CYCLES(D8), .MAX_BURST(M8)) dut8 (
    .Mclk(Mclk), .nReset(nReset), .cmd_valid(c8_valid), .cmd_ready(cmd_ready_8),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready_8), .BUS_IN(BUS_IN_8),
    .Data_Available(Data_Available_8), .Address(Address_8), .Read_RQ(Read_RQ_8),
    .busy(busy_8), .done(done_8), .err_len(err_len_8)
  );

  always #5 Mclk = ~Mclk;

  always @(posedge Mclk) cyc <= cyc + 1;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs sampled #1 later.
  task automatic step();
    @(posedge Mclk);
    #1;
  endtask

  // One full transaction on the main DUT, checked against the timing model.
  // stall[i] shifts when byte i becomes valid relative to its earliest push
  // opportunity (negative = already valid before the DUT can take it).
  task automatic run_txn(input bit rd, input logic [6:0] addr, input int len,
                         input logic [7:0] data [16], input int stall [16],
                         input bit hold_valid);
    int a, bi, da_n, done_cyc, exp_done, opp, budget;
    int p [16];
    int avail [16];
    bit bad_hold, bad_ready;
    bi = 0; da_n = 0; done_cyc = -1; bad_hold = 0; bad_ready = 0;
    step();
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = addr; cmd_len = 4'(len); wr_data_valid = 1'b0;
    #1;
    a = cyc;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || Read_RQ !== 1'b0)
      $display("FAIL accept_idle: cmd_ready=%b busy=%b Read_RQ=%b required 1/0/0", cmd_ready, busy, Read_RQ);
    else n_pass++;
    opp = a + 2;
    for (int i = 0; i < len; i++) begin
      avail[i] = opp + stall[i];
      p[i] = (rd || avail[i] <= opp) ? opp : avail[i];
      opp = p[i] + GAP + 2;
    end
    exp_done = p[len-1] + 1 + DRAIN + 1;
    budget = exp_done - a + 8;
    for (int n = 0; n < budget && done_cyc < 0; n++) begin
      step();
      if (hold_valid) begin
        cmd_valid = 1'b1; cmd_rd = ~rd; cmd_addr = ~addr; cmd_len = 4'd5;
      end else begin
        cmd_valid = 1'b0;
      end
      wr_data_valid = !rd && (bi < len) && (cyc >= avail[bi]);
      wr_data = (bi < len) ? data[bi] : 8'h00;
      #1;
      if (wr_data_ready === 1'b1) begin
        if (bi >= len || rd || cyc != p[bi]) bad_ready = 1;
        bi++;
      end
      if (Data_Available === 1'b1) begin
        if (da_n < len) begin
          n_checks++;
          if (cyc !== p[da_n] + 1)
            $display("FAIL push_time[%0d]: cycle %0d required %0d", da_n, cyc - a, p[da_n] + 1 - a);
          else n_pass++;
          n_checks++;
          if (BUS_IN !== (rd ? 8'h00 : data[da_n]))
            $display("FAIL push_data[%0d]: BUS_IN=%h required %h", da_n, BUS_IN, rd ? 8'h00 : data[da_n]);
          else n_pass++;
        end
        da_n++;
      end
      if (busy !== 1'b1 || Address !== addr || Read_RQ !== rd || cmd_ready !== 1'b0 || err_len !== 1'b0)
        bad_hold = 1;
      if (done === 1'b1) done_cyc = cyc;
    end
    wr_data_valid = 1'b0;
    n_checks++;
    if (done_cyc !== exp_done)
      $display("FAIL done_time: done at %0d required %0d (relative to accept, -1 = never)", done_cyc < 0 ? -1 : done_cyc - a, exp_done - a);
    else n_pass++;
    n_checks++;
    if (da_n !== len) $display("FAIL push_count: %0d pulses required %0d", da_n, len);
    else n_pass++;
    n_checks++;
    if (bad_hold) $display("FAIL hold_outputs: busy/Address/Read_RQ/cmd_ready/err_len not steady, required 1/%h/%0d/0/0", addr, rd);
    else n_pass++;
    n_checks++;
    if (bad_ready || (!rd && bi !== len))
      $display("FAIL wr_ready: %0d bytes consumed (misplaced=%0d) required %0d", bi, bad_ready, rd ? 0 : len);
    else n_pass++;
    $display("txn rd=%0d addr=%h len=%0d accept=%0d done=+%0d pushes=%0d", rd, addr, len, a, done_cyc - a, da_n);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) step();
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || cmd_ready_8 !== 1'b0)
      $display("FAIL reset_cmd_ready: %b/%b required 0", cmd_ready, cmd_ready_8);
    else n_pass++;
    n_checks++;
    if ({BUS_IN, Data_Available, Address, Read_RQ, busy, done, err_len, wr_data_ready} !== 21'd0)
      $display("FAIL reset_outputs: %h required 0", {BUS_IN, Data_Available, Address, Read_RQ, busy, done, err_len, wr_data_ready});
    else n_pass++;
    step();
    nReset = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL first_idle: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    else n_pass++;
    $display("txn reset released at cycle %0d", cyc);
  endtask

  task automatic test_write_basic();
    logic [7:0] d [16];
    int s [16];
    foreach (d[i]) begin d[i] = 8'h00; s[i] = 0; end
    d[0] = 8'hA5; d[1] = 8'h5A; d[2] = 8'hFF;
    run_txn(1'b0, 7'h12, 3, d, s, 1'b0);
  endtask

  task automatic test_read_basic();
    logic [7:0] d [16];
    int s [16];
    foreach (d[i]) begin d[i] = 8'($urandom); s[i] = 0; end
    run_txn(1'b1, 7'($urandom), 2, d, s, 1'b0);
  endtask

  task automatic test_stall();
    logic [7:0] d [16];
    int s [16];
    foreach (d[i]) begin d[i] = 8'($urandom); s[i] = 0; end
    s[1] = 20;
    run_txn(1'b0, 7'h2C, 2, d, s, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d [16];
    int s [16];
    int len;
    for (int t = 0; t < 6; t++) begin
      foreach (d[i]) begin
        d[i] = 8'($urandom);
        s[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) - 3 : 0;
      end
      len = (t == 0) ? 15 : int'($urandom_range(1, 15));
      run_txn((t == 0) ? 1'b0 : 1'($urandom), 7'($urandom), len, d, s, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [16];
    int s [16];
    foreach (d[i]) begin d[i] = 8'($urandom); s[i] = 0; end
    run_txn(1'b0, 7'h21, 2, d, s, 1'b1);
    run_txn(1'b1, 7'h5E, 1, d, s, 1'b0);
  endtask

  task automatic test_reject();
    int a;
    int n_da;
    int done_at;
    bit bad;
    // length 0 on the main DUT, with stray payload valid while idle
    step();
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_len = 4'd0; cmd_addr = 7'h55;
    #1;
    step();
    cmd_valid = 1'b0; wr_data_valid = 1'b1;
    #1;
    n_checks++;
    if (err_len !== 1'b1 || busy !== 1'b0)
      $display("FAIL reject0_pulse: err_len=%b busy=%b required 1/0", err_len, busy);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (err_len !== 1'b0) $display("FAIL reject0_single: err_len=%b required 0", err_len);
    else n_pass++;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      #1;
      if (Data_Available !== 1'b0 || busy !== 1'b0 || wr_data_ready !== 1'b0 || err_len !== 1'b0) bad = 1;
    end
    wr_data_valid = 1'b0;
    n_checks++;
    if (bad) $display("FAIL reject0_quiet: activity after reject, required none");
    else n_pass++;
    $display("txn reject len=0 err_len observed");
    // length MAX_BURST+1 on the MAX_BURST=8 instance
    step();
    c8_valid = 1'b1; cmd_rd = 1'b1; cmd_len = 4'd9; cmd_addr = 7'h0F;
    #1;
    step();
    c8_valid = 1'b0;
    #1;
    n_checks++;
    if (err_len_8 !== 1'b1 || busy_8 !== 1'b0 || Data_Available_8 !== 1'b0)
      $display("FAIL reject9_pulse: err_len=%b busy=%b DA=%b required 1/0/0", err_len_8, busy_8, Data_Available_8);
    else n_pass++;
    $display("txn reject len=9 on MAX_BURST=8");
    // length exactly MAX_BURST is accepted
    step();
    c8_valid = 1'b1; cmd_rd = 1'b1; cmd_len = 4'd8; cmd_addr = 7'h0F;
    #1;
    a = cyc;
    step();
    c8_valid = 1'b0;
    #1;
    n_checks++;
    if (busy_8 !== 1'b1 || err_len_8 !== 1'b0 || Read_RQ_8 !== 1'b1 || Address_8 !== 7'h0F)
      $display("FAIL accept8: busy=%b err_len=%b Read_RQ=%b Address=%h required 1/0/1/0f", busy_8, err_len_8, Read_RQ_8, Address_8);
    else n_pass++;
    n_da = 0; done_at = -1;
    for (int n = 0; n < 200 && done_at < 0; n++) begin
      step();
      #1;
      if (Data_Available_8 === 1'b1) n_da++;
      if (done_8 === 1'b1) done_at = cyc;
    end
    n_checks++;
    if (n_da !== 8) $display("FAIL accept8_pushes: %0d required 8", n_da);
    else n_pass++;
    n_checks++;
    if (done_at !== a + 3 + 7 * (G8 + 2) + D8 + 1)
      $display("FAIL accept8_done: %0d required %0d", done_at - a, 3 + 7 * (G8 + 2) + D8 + 1);
    else n_pass++;
    $display("txn len=8 on MAX_BURST=8 pushes=%0d done=+%0d", n_da, done_at - a);
  endtask

  task automatic test_reset_mid_drain();
    bit bad;
    step();
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 7'h33; cmd_len = 4'd1;
    #1;
    step();
    cmd_valid = 1'b0;
    repeat (9) step();
    #1;
    n_checks++;
    if (busy !== 1'b1 || Read_RQ !== 1'b1)
      $display("FAIL drain_busy: busy=%b Read_RQ=%b required 1/1", busy, Read_RQ);
    else n_pass++;
    step();
    nReset = 1'b0;
    #1;
    step();
    nReset = 1'b1;
    #1;
    n_checks++;
    if ({BUS_IN, Data_Available, Address, Read_RQ, busy, done, err_len, wr_data_ready} !== 21'd0)
      $display("FAIL midreset_outputs: %h required 0", {BUS_IN, Data_Available, Address, Read_RQ, busy, done, err_len, wr_data_ready});
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL midreset_ready: cmd_ready=%b required 1", cmd_ready);
    else n_pass++;
    bad = 0;
    for (int n = 0; n < DRAIN + 8; n++) begin
      step();
      #1;
      if (done !== 1'b0 || Data_Available !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) $display("FAIL midreset_no_done: activity after reset, required none");
    else n_pass++;
    $display("txn reset mid-drain at cycle %0d", cyc);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_reject();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
